// File: rtl/line_buffer_5row.sv
// Five-row vertical line buffer: four line memories cascade so each
// accepted pixel emits the aligned column of rows y-4..y.
module line_buffer_5row #(
  parameter logic [10:0] PIC_WIDTH  = 11'd250,
  parameter logic [10:0] PIC_HEIGHT = 11'd250,
  parameter int          WIDTH      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [WIDTH-1:0] dout4,
  output logic [WIDTH-1:0] dout5,
  output logic             valid_out,
  output logic             eol_out
);

  localparam int AW = (int'(PIC_WIDTH) > 1) ? $clog2(int'(PIC_WIDTH)) : 1;

  logic [10:0]      col_cnt;
  logic [10:0]      row_cnt;
  logic [10:0]      col_eff;
  logic [10:0]      row_eff;
  logic [10:0]      col_nxt;
  logic [10:0]      row_nxt;
  logic             last_col;
  logic             last_row;
  logic             primed;
  logic [AW-1:0]    addr;

  logic [WIDTH-1:0] l0 [PIC_WIDTH];
  logic [WIDTH-1:0] l1 [PIC_WIDTH];
  logic [WIDTH-1:0] l2 [PIC_WIDTH];
  logic [WIDTH-1:0] l3 [PIC_WIDTH];
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r3;

  // sof forces this pixel to (row 0, col 0) regardless of counters
  always_comb begin
    col_eff  = sof ? '0 : col_cnt;
    row_eff  = sof ? '0 : row_cnt;
    last_col = (col_eff == PIC_WIDTH - 11'd1);
    last_row = (row_eff == PIC_HEIGHT - 11'd1);
    primed   = (row_eff >= 11'd4);
    col_nxt  = last_col ? '0 : col_eff + 11'd1;
    row_nxt  = row_eff;
    if (last_col) begin
      row_nxt = last_row ? '0 : row_eff + 11'd1;
    end
  end

  assign addr = col_eff[AW-1:0];
  assign r0   = l0[addr];
  assign r1   = l1[addr];
  assign r2   = l2[addr];
  assign r3   = l3[addr];

  // Line storage carries no reset; it is never visible before priming
  always_ff @(posedge clk) begin
    if (valid_in) begin
      l0[addr] <= din;
      l1[addr] <= r0;
      l2[addr] <= r1;
      l3[addr] <= r2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
      dout4     <= '0;
      dout5     <= '0;
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
      if (valid_in) begin
        col_cnt   <= col_nxt;
        row_cnt   <= row_nxt;
        dout5     <= din;
        dout4     <= r0;
        dout3     <= r1;
        dout2     <= r2;
        dout1     <= r3;
        valid_out <= primed;
        eol_out   <= primed & last_col;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_5row.sv
// Scoreboard bench for line_buffer_5row: an image-array model predicts
// each output column; a monitor pops and compares every cycle.
module tb_line_buffer_5row;

  localparam int W = 8;
  localparam int H = 8;

  typedef struct packed {
    logic             v;
    logic             e;
    logic [4:0][23:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        sof;
  logic [23:0] din;
  logic [23:0] dout1, dout2, dout3, dout4, dout5;
  logic        valid_out;
  logic        eol_out;

  int errors = 0;
  int checks = 0;

  exp_t        q[$];
  logic [23:0] img [H][W];
  int          r = 0;
  int          c = 0;

  always #5 clk = ~clk;

  line_buffer_5row #(
    .PIC_WIDTH (11'd8),
    .PIC_HEIGHT(11'd8),
    .WIDTH     (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .sof      (sof),
    .din      (din),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3),
    .dout4    (dout4),
    .dout5    (dout5),
    .valid_out(valid_out),
    .eol_out  (eol_out)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h r=%0d c=%0d t=%0t",
               n, a, e, r, c, $time);
    end
  endtask

  function automatic logic [23:0] pat();
    return {8'h00, 8'(r), 8'(c)};
  endfunction

  // One input cycle: drive at negedge, update model, push expectation
  task automatic px(input logic v, input logic s, input logic [23:0] d);
    exp_t e;
    @(negedge clk);
    valid_in = v;
    sof      = s;
    din      = d;
    e        = '0;
    if (v) begin
      if (s) begin
        r = 0;
        c = 0;
      end
      img[r][c] = d;
      e.v = (r >= 4);
      e.e = e.v && (c == W - 1);
      if (e.v) begin
        for (int k = 0; k < 5; k++) e.d[k] = img[r - 4 + k][c];
      end
      c++;
      if (c == W) begin
        c = 0;
        r = (r + 1) % H;
      end
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0][23:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {dout5, dout4, dout3, dout2, dout1};
        chk("valid_out", 32'(valid_out), 32'(e.v));
        chk("eol_out", 32'(eol_out), 32'(e.e));
        if (e.v) begin
          for (int k = 0; k < 5; k++) begin
            chk($sformatf("dout%0d", k + 1), 32'(act[k]), 32'(e.d[k]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_eol"}, 32'(eol_out), 32'd0);
    chk({tag, "_d1"}, 32'(dout1), 32'd0);
    chk({tag, "_d2"}, 32'(dout2), 32'd0);
    chk({tag, "_d3"}, 32'(dout3), 32'd0);
    chk({tag, "_d4"}, 32'(dout4), 32'd0);
    chk({tag, "_d5"}, 32'(dout5), 32'd0);
  endtask

  initial begin : stim
    logic [4:0][23:0] snap;
    int n;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof      = 1'b0;
    din      = '0;
    #2;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Frame 1 with a 3-cycle stall before pixel (5,3)
    n = 0;
    while (n < W * H) begin
      if (r == 5 && c == 3) begin
        px(1'b0, 1'b0, 24'hdeadbe);
        snap = {dout5, dout4, dout3, dout2, dout1};
        px(1'b0, 1'b0, 24'h123456);
        px(1'b0, 1'b0, 24'h654321);
        px(1'b1, 1'b0, pat());
        chk("hold", 32'(snap != {dout5, dout4, dout3, dout2, dout1}), 32'd0);
        chk("hold_d5", 32'(dout5), 32'h000502);
      end else begin
        px(1'b1, 1'b0, pat());
      end
      n++;
    end

    // Frame 2 wraps in without sof
    for (int i = 0; i < W * H; i++) px(1'b1, 1'b0, pat());

    // Frame 3: sof lands mid-line at (5,2)
    for (int i = 0; i < 100 && !(r == 5 && c == 2); i++)
      px(1'b1, 1'b0, pat());
    px(1'b1, 1'b1, 24'h000000);
    chk("sof_col", 32'(c), 32'd1);

    for (int i = 0; i < 150; i++)
      px($urandom_range(0, 3) != 0, 1'b0, 24'($urandom));

    // Async reset between edges during row 6
    for (int i = 0; i < 100 && !(r == 6 && c == 3); i++)
      px(1'b1, 1'b0, 24'($urandom));
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    r = 0;
    c = 0;

    for (int i = 0; i < 60; i++)
      px($urandom_range(0, 4) != 0, 1'b0, 24'($urandom));
    px(1'b1, 1'b1, 24'($urandom));
    for (int i = 0; i < 60; i++)
      px(1'b1, 1'b0, 24'($urandom));

    px(1'b0, 1'b0, 24'h0);
    @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_5row.md
Name: line_buffer_5row

Overview:
- Upstream neighbour of the 5x5 window/Gaussian stage.
- Accepts a raster-order 24-bit RGB pixel stream and buffers the four previous image lines in on-chip memory.
- Each valid pixel presents five vertically aligned pixels (rows y-4 to y, same column) on dout1..dout5, which wire directly to din1..din5 of the 5x5 stage.
- Suppresses output until five lines have been seen in the current frame.

Parameters:
- PIC_WIDTH, 11'd250: pixels per line; legal range 5..2047.
- PIC_HEIGHT, 11'd250: lines per frame; legal range 5..2047.
- WIDTH, 24: pixel data width, {R[23:16], G[15:8], B[7:0]}.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- valid_in  input  1  din is a valid pixel this cycle.
- sof  input  1  start of frame; qualified by valid_in; marks din as pixel (row 0, col 0).
- din  input  WIDTH  incoming pixel.
- dout1  output  WIDTH  pixel of row y-4 (oldest line), same column.
- dout2  output  WIDTH  pixel of row y-3.
- dout3  output  WIDTH  pixel of row y-2.
- dout4  output  WIDTH  pixel of row y-1.
- dout5  output  WIDTH  pixel of row y (current, i.e. registered din).
- valid_out  output  1  dout1..dout5 form a fully primed column.
- eol_out  output  1  qualified by valid_out; column presented is the last of its line (col = PIC_WIDTH-1).

Behaviour:
- Reset: dout1..dout5 = 0, valid_out = 0, eol_out = 0, col_cnt = 0, row_cnt = 0. Line memories are not reset; their contents are never exposed before priming.
- Storage: four line memories L0..L3, each PIC_WIDTH x WIDTH, all addressed by col_cnt.
- Per accepted pixel (valid_in = 1), one cycle, read-before-write at address col_cnt:
  - dout5 <= din; dout4 <= L0[col]; dout3 <= L1[col]; dout2 <= L2[col]; dout1 <= L3[col].
  - L0[col] <= din; L1[col] <= old L0[col]; L2[col] <= old L1[col]; L3[col] <= old L2[col] (cascade shift).
- Latency: exactly 1 clock from accepted din to the corresponding dout5 and valid_out.
- col_cnt: increments per accepted pixel; on PIC_WIDTH-1 it wraps to 0 and row_cnt increments. row_cnt wraps from PIC_HEIGHT-1 to 0 on the last pixel of a frame.
- Pause: valid_in = 0 holds col_cnt, row_cnt, memories and dout1..dout5; valid_out and eol_out drop to 0 on the next edge.
- valid_out <= valid_in AND (row_cnt >= 4), evaluated on the pre-increment row_cnt of the accepted pixel. Rows 0..3 of every frame produce no valid_out.
- eol_out <= valid_in AND (row_cnt >= 4) AND (col_cnt == PIC_WIDTH-1).
- sof with valid_in: the pixel is treated as col 0, row 0, whatever the counters hold.
  - After that pixel: col_cnt = 1 (0 if PIC_WIDTH = 1, which is illegal), row_cnt = 0.
  - Priming restarts and valid_out stays 0 for that pixel.
  - The pixel is still written to memory at address 0 with the normal cascade.
- sof without valid_in: ignored.
- Frame wrap without sof: row_cnt returning to 0 also restarts priming, so rows 0..3 of the next frame produce no valid_out.
- Reset mid-frame: all counters and outputs return to reset values immediately. The next accepted pixel is row 0, col 0.
- Memories are inferable as simple dual-port RAM or registers. Data must be byte-exact pass-through with no arithmetic.

Test Plan:
- Priming, PIC_WIDTH=8, PIC_HEIGHT=8, din = {8'h0, row, col}, continuous valid_in from reset: valid_out stays 0 for the first 32 pixels. It first rises 1 cycle after pixel (4,0), with dout1..dout5 = 0x000000, 0x000100, 0x000200, 0x000300, 0x000400.
- Steady column alignment, same setup: at pixel (6,5), the outputs next cycle are dout1=0x000205, dout2=0x000305, dout3=0x000405, dout4=0x000505, dout5=0x000605. eol_out=1 only for col 7 in rows 4..7.
- Stall: de-assert valid_in for 3 cycles mid-line 5 at col 3. valid_out=0 during the gap and dout values hold. Resuming with (5,3) gives dout1=0x000103, with no skipped or duplicated column.
- Frame wrap: after pixel (7,7), feed the next frame with no sof. valid_out stays 0 for 32 pixels, then resumes with dout5=0x000400 of the new frame.
- Mid-frame sof: assert sof with valid_in at row 5 col 2. That pixel gives no valid_out, the next pixel is col 1 of row 0, and priming takes 32 pixels again.
- Async reset: pulse rst_n low between clock edges during row 6. All outputs read 0 before the next clk edge and stay 0 through priming of a new 32-pixel run.
